// File: rtl/sodor_mem_pkg.sv
// Shared definitions for the Sodor memory arbiter slice: memory function
// and access-size codes plus the helper that sizes port tags.
// Optional feature macro used by the arbiter: SODOR_MEM_ARB_PERF_EN.
package sodor_mem_pkg;

    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    localparam int TYP_W = 3;

    localparam logic [TYP_W-1:0] MT_B  = 3'd1;
    localparam logic [TYP_W-1:0] MT_H  = 3'd2;
    localparam logic [TYP_W-1:0] MT_W  = 3'd3;
    localparam logic [TYP_W-1:0] MT_BU = 3'd5;
    localparam logic [TYP_W-1:0] MT_HU = 3'd6;

    // A single-port arbiter still needs a one-bit tag so vectors never collapse to zero width.
    function automatic int port_tag_width(input int nports);
        return (nports <= 1) ? 1 : $clog2(nports);
    endfunction

endpackage

// File: rtl/sodor_mem_arbiter_if.sv
// Bundle of the requester-side and memory-side handshake signals of the
// Sodor memory arbiter. The arbiter takes the slave view; whatever drives
// the requests and models the memory takes the master view.
interface sodor_mem_arbiter_if
    import sodor_mem_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int XLEN   = 32
);
    logic [NPORTS-1:0]       io_port_req_valid;
    logic [NPORTS-1:0]       io_port_req_ready;
    logic [NPORTS*XLEN-1:0]  io_port_req_bits_addr;
    logic [NPORTS*XLEN-1:0]  io_port_req_bits_data;
    logic [NPORTS-1:0]       io_port_req_bits_fcn;
    logic [NPORTS*TYP_W-1:0] io_port_req_bits_typ;
    logic [NPORTS-1:0]       io_port_resp_valid;
    logic [XLEN-1:0]         io_port_resp_bits_data;

    logic                    io_mem_req_valid;
    logic                    io_mem_req_ready;
    logic [XLEN-1:0]         io_mem_req_bits_addr;
    logic [XLEN-1:0]         io_mem_req_bits_data;
    logic                    io_mem_req_bits_fcn;
    logic [TYP_W-1:0]        io_mem_req_bits_typ;
    logic                    io_mem_resp_valid;
    logic [XLEN-1:0]         io_mem_resp_bits_data;

    logic                    io_err_orphan_resp;

    modport slave (
        input  io_port_req_valid, io_port_req_bits_addr, io_port_req_bits_data,
               io_port_req_bits_fcn, io_port_req_bits_typ,
               io_mem_req_ready, io_mem_resp_valid, io_mem_resp_bits_data,
        output io_port_req_ready, io_port_resp_valid, io_port_resp_bits_data,
               io_mem_req_valid, io_mem_req_bits_addr, io_mem_req_bits_data,
               io_mem_req_bits_fcn, io_mem_req_bits_typ, io_err_orphan_resp
    );

    modport master (
        output io_port_req_valid, io_port_req_bits_addr, io_port_req_bits_data,
               io_port_req_bits_fcn, io_port_req_bits_typ,
               io_mem_req_ready, io_mem_resp_valid, io_mem_resp_bits_data,
        input  io_port_req_ready, io_port_resp_valid, io_port_resp_bits_data,
               io_mem_req_valid, io_mem_req_bits_addr, io_mem_req_bits_data,
               io_mem_req_bits_fcn, io_mem_req_bits_typ, io_err_orphan_resp
    );

endinterface

// File: rtl/sodor_mem_arb_tag_fifo.sv
// In-order FIFO of requester tags for requests that are still waiting for
// their memory response. Head is the owner of the next response.
module sodor_mem_arb_tag_fifo
    import sodor_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output logic [TAG_W-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0] tags [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = tags[rd_ptr];

    // Pointers wrap naturally; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clock) begin
        if (push_ok) tags[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/sodor_mem_arbiter.sv
// Round-robin arbiter merging NPORTS Sodor memory request streams onto one
// memory port, routing in-order responses back through a tag FIFO.
// Optional: define SODOR_MEM_ARB_PERF_EN to add per-port grant counters.
module sodor_mem_arbiter
    import sodor_mem_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    sodor_mem_arbiter_if.slave     bus
`ifdef SODOR_MEM_ARB_PERF_EN
    ,
    output logic [NPORTS*32-1:0]   io_perf_grant_cnt
`endif
);
    localparam int TAG_W = port_tag_width(NPORTS);
    localparam int PTR_W = $clog2(DEPTH);

    logic [TAG_W-1:0]    rr_ptr;
    logic [TAG_W-1:0]    winner;
    logic [TAG_W-1:0]    fifo_head;
    logic [PTR_W:0]      fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                found;
    logic                handshake;
    logic                pop;
    logic                orphan_q;
    logic [2*NPORTS-1:0] valid_rot;

    // Search for the first valid port at or after rr_ptr, wrapping around.
    always_comb begin
        int w;
        w         = 0;
        found     = 1'b0;
        winner    = '0;
        valid_rot = {bus.io_port_req_valid, bus.io_port_req_valid} >> rr_ptr;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                w = int'(rr_ptr) + i;
                if (w >= NPORTS) w = w - NPORTS;
                found  = 1'b1;
                winner = TAG_W'(w);
            end
        end
    end

    assign bus.io_mem_req_valid = reset && found && !fifo_full;
    assign handshake            = bus.io_mem_req_valid && bus.io_mem_req_ready;
    assign pop                  = reset && bus.io_mem_resp_valid && (fifo_count != '0);

    // Steer the winner's fields to memory and fan out ready and response strobes.
    always_comb begin
        bus.io_mem_req_bits_addr = '0;
        bus.io_mem_req_bits_data = '0;
        bus.io_mem_req_bits_fcn  = 1'b0;
        bus.io_mem_req_bits_typ  = '0;
        bus.io_port_req_ready    = '0;
        bus.io_port_resp_valid   = '0;
        for (int j = 0; j < NPORTS; j++) begin
            if (reset && found && winner == TAG_W'(j)) begin
                bus.io_mem_req_bits_addr = bus.io_port_req_bits_addr[j*XLEN +: XLEN];
                bus.io_mem_req_bits_data = bus.io_port_req_bits_data[j*XLEN +: XLEN];
                bus.io_mem_req_bits_fcn  = bus.io_port_req_bits_fcn[j];
                bus.io_mem_req_bits_typ  = bus.io_port_req_bits_typ[j*TYP_W +: TYP_W];
            end
            bus.io_port_req_ready[j]  = handshake && (winner == TAG_W'(j));
            bus.io_port_resp_valid[j] = pop && (fifo_head == TAG_W'(j));
        end
    end

    assign bus.io_port_resp_bits_data = reset ? bus.io_mem_resp_bits_data : '0;
    assign bus.io_err_orphan_resp     = orphan_q;

    // Advance the round-robin pointer past each granted port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (winner == TAG_W'(NPORTS - 1)) ? '0 : winner + 1'b1;
        end
    end

    // A response with nothing outstanding is latched as an error until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            orphan_q <= 1'b0;
        end else if (bus.io_mem_resp_valid && fifo_empty) begin
            orphan_q <= 1'b1;
        end
    end

    sodor_mem_arb_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (handshake),
        .push_tag (winner),
        .pop      (pop),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef SODOR_MEM_ARB_PERF_EN
    logic [31:0] grant_cnt [NPORTS];

    // Free-running per-port grant counters, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < NPORTS; j++) grant_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < NPORTS; j++) begin
                if (handshake && winner == TAG_W'(j)) grant_cnt[j] <= grant_cnt[j] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_perf
        assign io_perf_grant_cnt[g*32 +: 32] = grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_sodor_mem_arbiter.sv
// Randomized self-checking bench for sodor_mem_arbiter against a queue-based
// model of the arbitration and in-order response routing rules.
// Honours SODOR_MEM_ARB_PERF_EN when the design is built with it.
module tb_sodor_mem_arbiter;
    import sodor_mem_pkg::*;

    localparam int NPORTS = 3;
    localparam int XLEN   = 32;
    localparam int DEPTH  = 4;

    logic clock;
    logic reset;

    int errors;
    int checks;

    // Behavioural model state
    int          tag_q[$];
    int          rr;
    bit          orph;
    int          gcnt[NPORTS];

    // Pending requester state (held stable until granted)
    bit          pv[NPORTS];
    logic [31:0] pa[NPORTS];
    logic [31:0] pd[NPORTS];
    logic        pf[NPORTS];
    logic [2:0]  pt[NPORTS];

    sodor_mem_arbiter_if #(.NPORTS(NPORTS), .XLEN(XLEN)) bus ();

`ifdef SODOR_MEM_ARB_PERF_EN
    logic [NPORTS*32-1:0] perf_cnt;
`endif

    sodor_mem_arbiter #(
        .NPORTS (NPORTS),
        .XLEN   (XLEN),
        .DEPTH  (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef SODOR_MEM_ARB_PERF_EN
        ,
        .io_perf_grant_cnt (perf_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive the bus for one cycle: new random requests on idle ports, random memory behaviour.
    task automatic applyStimulus(input bit rst_val, input int vpct, input int rdy_pct,
                                 input int resp_pct, input bit allow_orph);
        reset = rst_val;
        for (int p = 0; p < NPORTS; p++) begin
            if (!pv[p]) begin
                pv[p] = ($urandom_range(0, 99) < vpct);
                pa[p] = $urandom;
                pd[p] = $urandom;
                pf[p] = 1'($urandom_range(0, 1));
                pt[p] = 3'($urandom_range(0, 7));
            end
            bus.io_port_req_valid[p]                     = pv[p];
            bus.io_port_req_bits_addr[p*XLEN +: XLEN]    = pa[p];
            bus.io_port_req_bits_data[p*XLEN +: XLEN]    = pd[p];
            bus.io_port_req_bits_fcn[p]                  = pf[p];
            bus.io_port_req_bits_typ[p*TYP_W +: TYP_W]   = pt[p];
        end
        bus.io_mem_req_ready      = ($urandom_range(0, 99) < rdy_pct);
        bus.io_mem_resp_valid     = ($urandom_range(0, 99) < resp_pct) &&
                                    (tag_q.size() > 0 || allow_orph);
        bus.io_mem_resp_bits_data = 32'h1000 + $urandom_range(0, 4095);
    endtask

    // Compare DUT against the model for this cycle, then advance the model past the coming edge.
    task automatic stepModel();
        int                win;
        bit                exp_mv;
        logic [NPORTS-1:0] exp_ready;
        logic [NPORTS-1:0] exp_resp;
        logic [NPORTS-1:0] one;
        bit                popped;
        one = 1;
        if (!reset) begin
            tag_q.delete();
            rr   = 0;
            orph = 0;
            for (int p = 0; p < NPORTS; p++) begin
                gcnt[p] = 0;
            end
        end
        win = -1;
        for (int k = 0; k < NPORTS; k++) begin
            int p;
            p = (rr + k) % NPORTS;
            if (win < 0 && pv[p]) win = p;
        end
        exp_mv    = reset && (win >= 0) && (tag_q.size() < DEPTH);
        exp_ready = (exp_mv && bus.io_mem_req_ready) ? (one << win) : '0;
        popped    = reset && bus.io_mem_resp_valid && (tag_q.size() > 0);
        exp_resp  = popped ? (one << tag_q[0]) : '0;

        checkOutput("mem_req_valid", 64'(bus.io_mem_req_valid), 64'(exp_mv));
        checkOutput("port_req_ready", 64'(bus.io_port_req_ready), 64'(exp_ready));
        checkOutput("port_resp_valid", 64'(bus.io_port_resp_valid), 64'(exp_resp));
        checkOutput("err_orphan", 64'(bus.io_err_orphan_resp), 64'(orph));
        if (exp_mv) begin
            checkOutput("mem_addr", 64'(bus.io_mem_req_bits_addr), 64'(pa[win]));
            checkOutput("mem_data", 64'(bus.io_mem_req_bits_data), 64'(pd[win]));
            checkOutput("mem_fcn", 64'(bus.io_mem_req_bits_fcn), 64'(pf[win]));
            checkOutput("mem_typ", 64'(bus.io_mem_req_bits_typ), 64'(pt[win]));
        end
        if (popped) begin
            checkOutput("resp_data", 64'(bus.io_port_resp_bits_data), 64'(bus.io_mem_resp_bits_data));
        end

        if (!reset) begin
            for (int p = 0; p < NPORTS; p++) pv[p] = 0;
            return;
        end
        if (bus.io_mem_resp_valid && tag_q.size() == 0) orph = 1;
        if (popped) void'(tag_q.pop_front());
        if (exp_ready != '0) begin
            tag_q.push_back(win);
            rr = (win + 1) % NPORTS;
            gcnt[win]++;
            pv[win] = 0;
        end
    endtask

    task automatic runCycle(input bit rst_val, input int vpct, input int rdy_pct,
                            input int resp_pct, input bit allow_orph);
        @(negedge clock);
        applyStimulus(rst_val, vpct, rdy_pct, resp_pct, allow_orph);
        #1;
        stepModel();
    endtask

    initial begin
        int guard;
        errors = 0;
        checks = 0;
        rr     = 0;
        orph   = 0;
        reset  = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            pv[p]   = 0;
            gcnt[p] = 0;
        end
        applyStimulus(1'b0, 0, 0, 0, 1'b0);

        // Reset state, including outputs gated while requests are presented
        repeat (2) runCycle(1'b0, 100, 100, 0, 1'b0);

        // Response with nothing outstanding latches the orphan flag
        repeat (2) runCycle(1'b1, 0, 100, 100, 1'b1);
        repeat (3) runCycle(1'b1, 0, 100, 0, 1'b0);
        runCycle(1'b0, 0, 100, 0, 1'b0);

        // All ports busy, memory always ready and responding
        repeat (12) runCycle(1'b1, 100, 100, 100, 1'b0);

        // Memory stalled, requests must hold and nothing is granted
        repeat (5) runCycle(1'b1, 100, 0, 0, 1'b0);
        repeat (2) runCycle(1'b1, 100, 100, 100, 1'b0);

        // Fill the tag FIFO, then a pop while full must not grant that cycle
        repeat (6) runCycle(1'b1, 100, 100, 0, 1'b0);
        runCycle(1'b1, 100, 100, 100, 1'b0);
        runCycle(1'b1, 100, 100, 0, 1'b0);
        repeat (6) runCycle(1'b1, 0, 100, 100, 1'b0);

        // Random traffic
        repeat (400) runCycle(1'b1, 60, 75, 35, 1'b0);

        // Reset with requests in flight, then a stale response
        guard = 0;
        while (tag_q.size() < 3 && guard < 40) begin
            runCycle(1'b1, 100, 100, 0, 1'b0);
            guard++;
        end
        checkOutput("fill_before_reset", 64'(tag_q.size() >= 3), 64'(1));
        runCycle(1'b0, 0, 100, 0, 1'b0);
        runCycle(1'b1, 0, 100, 100, 1'b1);
        repeat (2) runCycle(1'b1, 0, 100, 0, 1'b0);

`ifdef SODOR_MEM_ARB_PERF_EN
        repeat (30) runCycle(1'b1, 70, 80, 40, 1'b0);
        @(posedge clock);
        #1;
        for (int p = 0; p < NPORTS; p++) begin
            checkOutput("perf_grant_cnt", 64'(perf_cnt[p*32 +: 32]), 64'(gcnt[p]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
